// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch sequencer.
// States, fault causes and the fetch step size.
package riscv_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    VALID,
    DRAIN,
    FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BUS      = 2'd1,
    CAUSE_TIMEOUT  = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } fault_cause_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC block and a single-outstanding
// imem port, handing fetched words to decode over valid/ready.
module fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic        pc_load,
  output logic [31:0] pc_step,
  output logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WONE = WW'(1);

  fetch_state_t  state_q, state_d;
  fault_cause_t  cause_q, cause_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   ipc_q, ipc_d;

  logic redir_ok, redir_bad, busy, timeout;

  always_comb begin
    redir_ok  = rst && redirect_valid
              && (redirect_target[1:0] == 2'b00);
    redir_bad = rst && redirect_valid
              && (redirect_target[1:0] != 2'b00);
    busy      = (state_q == REQ) || (state_q == DRAIN);
    timeout   = busy && !imem_ack
              && ((32'(wait_q) + 32'd1) >= MAX_WAIT);

    state_d   = state_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ipc_d     = ipc_q;
    wait_d    = '0;
    pc_enable = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    imem_req  = 1'b0;
    imem_addr = '0;

    unique case (state_q)
      IDLE: begin
        if (!halt) state_d = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        addr_d    = pc;
        if (imem_ack && imem_err) begin
          state_d = FAULT;
          cause_d = CAUSE_BUS;
        end else if (imem_ack) begin
          data_d    = imem_rdata;
          ipc_d     = pc;
          pc_enable = 1'b1;
          state_d   = VALID;
        end else if (timeout) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      VALID: begin
        if (inst_ready) state_d = halt ? IDLE : REQ;
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          state_d = REQ;
        end else if (timeout) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides every event above, including a same-cycle ack.
    if (redir_ok) begin
      pc_enable = 1'b1;
      pc_load   = 1'b1;
      pc_target = redirect_target;
      data_d    = data_q;
      ipc_d     = ipc_q;
      cause_d   = CAUSE_NONE;
      state_d   = busy ? DRAIN : REQ;
    end else if (redir_bad) begin
      pc_enable = 1'b0;
      data_d    = data_q;
      ipc_d     = ipc_q;
      cause_d   = CAUSE_MISALIGN;
      state_d   = FAULT;
    end

    if (busy && !imem_ack
        && ((state_d == REQ) || (state_d == DRAIN)))
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + WONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  assign pc_step     = INSTR_BYTES;
  assign inst_valid  = (state_q == VALID);
  assign inst_data   = data_q;
  assign inst_pc     = ipc_q;
  assign fetch_fault = (state_q == FAULT);
  assign fault_cause = cause_q;

endmodule
